// File: rtl/eth1g_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | eth1g_pkg                                                            |
// | Shared constants, FSM encoding and byte helpers for the eth1g TX.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package eth1g_pkg;

  localparam logic [7:0]  GMII_PREAMBLE = 8'h55;
  localparam logic [7:0]  GMII_SFD      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_DATA     = 3'd3,
    ST_PAD      = 3'd4,
    ST_FCS      = 3'd5,
    ST_ABORT    = 3'd6,
    ST_IFG      = 3'd7
  } tx_state_e;

  // Bit reversal, used to derive the LSB-first form of the polynomial.
  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Index of the last valid byte lane of a word. Non-last words always carry
  // four bytes; a last word counts its leading ones with a floor of one.
  function automatic logic [1:0] be_last_lane(input logic [3:0] be, input logic last);
    logic [1:0] ll;
    if (!last) begin
      ll = 2'd3;
    end else begin
      casez (be)
        4'b1111: ll = 2'd3;
        4'b1110: ll = 2'd2;
        4'b110?: ll = 2'd1;
        default: ll = 2'd0;
      endcase
    end
    return ll;
  endfunction

  // Byte lane select, lane 0 is the most significant byte.
  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth1g_crc32_d8.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | eth1g_crc32_d8                                                       |
// | Byte-per-clock IEEE 802.3 CRC-32, reflected form, registered state.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module eth1g_crc32_d8
  import eth1g_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  din_i,
  output logic [31:0] crc_o
);

  localparam logic [31:0] POLY_REFL = bit_rev32(CRC32_POLY);

  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic [31:0] step;

  // Eight LSB-first shift steps per byte; init has priority over update.
  always_comb begin
    step = crc_q;
    for (int i = 0; i < 8; i++) begin
      if (step[0] ^ din_i[i]) step = (step >> 1) ^ POLY_REFL;
      else                    step = step >> 1;
    end
    crc_d = crc_q;
    if (init_i)    crc_d = CRC32_INIT;
    else if (en_i) crc_d = step;
  end

  // CRC state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= CRC32_INIT;
    else        crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule
`default_nettype wire

// File: rtl/eth1g_gmii_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | eth1g_gmii_tx                                                        |
// | 32-bit word stream to GMII: preamble/SFD, pad, FCS, IFG, underrun.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module eth1g_gmii_tx
  import eth1g_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int IFG_BYTES    = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] tx_data_in,
  input  logic [3:0]  tx_be_in,
  input  logic        tx_data_in_last,
  input  logic        tx_data_in_rdy,
  output logic        tx_data_in_rd,
  output logic        tx_busy,
  output logic        tx_underrun,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er
);

  // Each state names the byte slot currently on the wire; every edge picks the
  // next slot and registers its byte and strobes together.
  tx_state_e   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  lastlane_q, lastlane_d;
  logic        last_q, last_d;
  logic [31:0] word_q, word_d;
  logic [10:0] bytecnt_q, bytecnt_d;
  logic [10:0] bytecnt_inc;
  logic [7:0]  txd_q, txd_d;
  logic        en_q, en_d;
  logic        er_q, er_d;
  logic        busy_q, busy_d;
  logic        rd_q, rd_d;
  logic        und_q, und_d;
  logic        crc_init, crc_en;
  logic [31:0] crc;
  logic        start, load, tail;

  eth1g_crc32_d8 u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .init_i (crc_init),
    .en_i   (crc_en),
    .din_i  (txd_d),
    .crc_o  (crc)
  );

  // Next-slot selection. rd is raised for the slot during which the word is
  // consumed, and the word is latched at the edge that ends that slot, so the
  // FWFT source still shows it when we capture it.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lane_d     = lane_q;
    lastlane_d = lastlane_q;
    last_d     = last_q;
    word_d     = word_q;
    bytecnt_d  = bytecnt_q;
    txd_d      = 8'h00;
    en_d       = 1'b0;
    er_d       = 1'b0;
    und_d      = 1'b0;
    busy_d     = busy_q;
    rd_d       = 1'b0;
    crc_init   = 1'b0;
    crc_en     = 1'b0;
    start      = 1'b0;
    load       = 1'b0;
    tail       = 1'b0;
    bytecnt_inc = (bytecnt_q == 11'h7FF) ? bytecnt_q : bytecnt_q + 11'd1;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        start  = tx_data_in_rdy;
      end
      ST_PREAMBLE: begin
        en_d = 1'b1;
        if (cnt_q == 8'(PREAMBLE_LEN - 1)) begin
          state_d = ST_SFD;
          txd_d   = GMII_SFD;
          rd_d    = tx_data_in_rdy;
        end else begin
          cnt_d = cnt_q + 8'd1;
          txd_d = GMII_PREAMBLE;
        end
      end
      ST_SFD: load = 1'b1;
      ST_DATA: begin
        if (lane_q != lastlane_q) begin
          lane_d    = lane_q + 2'd1;
          en_d      = 1'b1;
          txd_d     = byte_of(word_q, lane_d);
          bytecnt_d = bytecnt_inc;
          crc_en    = 1'b1;
          if (lane_d == lastlane_q && !last_q) rd_d = tx_data_in_rdy;
        end else if (!last_q) begin
          load = 1'b1;
        end else begin
          tail = 1'b1;
        end
      end
      ST_PAD: tail = 1'b1;
      ST_FCS: begin
        if (cnt_q != 8'd3) begin
          cnt_d = cnt_q + 8'd1;
          en_d  = 1'b1;
          txd_d = ~byte_of(crc, ~cnt_d[1:0]);
        end else begin
          state_d = ST_IFG;
          cnt_d   = 8'd0;
        end
      end
      ST_ABORT: begin
        state_d = ST_IFG;
        cnt_d   = 8'd0;
      end
      ST_IFG: begin
        if (cnt_q == 8'(IFG_BYTES - 1)) begin
          // A waiting frame chains straight into its preamble so the gap is
          // exactly IFG_BYTES clocks; otherwise drop to idle.
          if (tx_data_in_rdy) begin
            start = 1'b1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d   = ST_PREAMBLE;
      cnt_d     = 8'd0;
      en_d      = 1'b1;
      txd_d     = GMII_PREAMBLE;
      busy_d    = 1'b1;
      crc_init  = 1'b1;
      bytecnt_d = 11'd0;
    end

    // A missing rd means the source was not ready: abort with one error byte.
    if (load) begin
      if (rd_q) begin
        state_d    = ST_DATA;
        word_d     = tx_data_in;
        last_d     = tx_data_in_last;
        lastlane_d = be_last_lane(tx_be_in, tx_data_in_last);
        lane_d     = 2'd0;
        en_d       = 1'b1;
        txd_d      = tx_data_in[31:24];
        bytecnt_d  = bytecnt_inc;
        crc_en     = 1'b1;
      end else begin
        state_d = ST_ABORT;
        en_d    = 1'b1;
        er_d    = 1'b1;
        und_d   = 1'b1;
      end
    end

    if (tail) begin
      en_d = 1'b1;
      if (bytecnt_q < 11'(MIN_FRAME)) begin
        state_d   = ST_PAD;
        txd_d     = 8'h00;
        bytecnt_d = bytecnt_inc;
        crc_en    = 1'b1;
      end else begin
        state_d = ST_FCS;
        cnt_d   = 8'd0;
        txd_d   = ~crc[7:0];
      end
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      lane_q     <= 2'd0;
      lastlane_q <= 2'd0;
      last_q     <= 1'b0;
      word_q     <= 32'd0;
      bytecnt_q  <= 11'd0;
      txd_q      <= 8'h00;
      en_q       <= 1'b0;
      er_q       <= 1'b0;
      busy_q     <= 1'b0;
      rd_q       <= 1'b0;
      und_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lane_q     <= lane_d;
      lastlane_q <= lastlane_d;
      last_q     <= last_d;
      word_q     <= word_d;
      bytecnt_q  <= bytecnt_d;
      txd_q      <= txd_d;
      en_q       <= en_d;
      er_q       <= er_d;
      busy_q     <= busy_d;
      rd_q       <= rd_d;
      und_q      <= und_d;
    end
  end

  assign gmii_txd      = txd_q;
  assign gmii_tx_en    = en_q;
  assign gmii_tx_er    = er_q;
  assign tx_busy       = busy_q;
  assign tx_data_in_rd = rd_q;
  assign tx_underrun   = und_q;

endmodule
`default_nettype wire

// File: tb/tb_eth1g_gmii_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_eth1g_gmii_tx                                                     |
// | Self-checking bench: frame-level model of the GMII byte stream.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_eth1g_gmii_tx;

  localparam int PRE  = 7;
  localparam int MINF = 60;
  localparam int IFG  = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] tx_data_in;
  logic [3:0]  tx_be_in;
  logic        tx_data_in_last;
  logic        tx_data_in_rdy;
  logic        tx_data_in_rd;
  logic        tx_busy;
  logic        tx_underrun;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en;
  logic        gmii_tx_er;

  always #4 clk = ~clk;

  eth1g_gmii_tx #(.PREAMBLE_LEN(PRE), .MIN_FRAME(MINF), .IFG_BYTES(IFG)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tx_data_in      (tx_data_in),
    .tx_be_in        (tx_be_in),
    .tx_data_in_last (tx_data_in_last),
    .tx_data_in_rdy  (tx_data_in_rdy),
    .tx_data_in_rd   (tx_data_in_rd),
    .tx_busy         (tx_busy),
    .tx_underrun     (tx_underrun),
    .gmii_txd        (gmii_txd),
    .gmii_tx_en      (gmii_tx_en),
    .gmii_tx_er      (gmii_tx_er)
  );

  typedef struct packed {logic en; logic er; logic und; logic [7:0] d;} item_t;
  typedef struct packed {logic [31:0] d; logic [3:0] be; logic last; logic hold;} word_t;

  item_t exp_q[$];
  word_t src_q[$];
  int checks = 0;
  int failures = 0;
  logic active;
  int en_run, last_run, gap, last_gap, und_cnt;
  logic rd_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [3:0] canon_be(input int rem);
    if (rem >= 4) return 4'b1111;
    if (rem == 3) return 4'b1110;
    if (rem == 2) return 4'b1100;
    return 4'b1000;
  endfunction

  function automatic int lead_ones(input logic [3:0] be);
    int n;
    n = 0;
    for (int i = 3; i >= 0; i--) begin
      if (!be[i]) break;
      n++;
    end
    return (n == 0) ? 1 : n;
  endfunction

  task automatic push_item(input logic en, input logic er, input logic und, input logic [7:0] d);
    exp_q.push_back(item_t'{en, er, und, d});
  endtask

  // Queue a frame at the source and its expected wire image. stall_word >= 0
  // marks a word the source never makes ready; belast < 0 means canonical be.
  task automatic send_frame(input int nbytes, input int stall_word,
                            input logic [3:0] be0, input int belast);
    int nw;
    int k;
    logic [7:0] fb[$];
    logic [31:0] c;
    word_t w;
    nw = (nbytes + 3) / 4;
    for (int i = 0; i < nw; i++) begin
      w.d    = $urandom;
      w.last = (i == nw - 1);
      w.hold = (i == stall_word);
      if (w.last) w.be = (belast >= 0) ? belast[3:0] : canon_be(nbytes - 4 * i);
      else        w.be = (i == 0) ? be0 : 4'b1111;
      k = w.last ? lead_ones(w.be) : 4;
      if (stall_word < 0 || i < stall_word)
        for (int j = 0; j < k; j++) fb.push_back(w.d[31 - 8 * j -: 8]);
      src_q.push_back(w);
    end
    for (int i = 0; i < PRE; i++) push_item(1'b1, 1'b0, 1'b0, 8'h55);
    push_item(1'b1, 1'b0, 1'b0, 8'hD5);
    if (stall_word >= 0) begin
      foreach (fb[i]) push_item(1'b1, 1'b0, 1'b0, fb[i]);
      push_item(1'b1, 1'b1, 1'b1, 8'h00);
    end else begin
      while (fb.size() < MINF) fb.push_back(8'h00);
      c = 32'hFFFFFFFF;
      foreach (fb[i]) begin
        c = crc_byte(c, fb[i]);
        push_item(1'b1, 1'b0, 1'b0, fb[i]);
      end
      c = ~c;
      for (int i = 0; i < 4; i++) push_item(1'b1, 1'b0, 1'b0, c[8 * i +: 8]);
    end
    for (int i = 0; i < IFG; i++) push_item(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic drive_src();
    if (src_q.size() > 0) begin
      tx_data_in      = src_q[0].d;
      tx_be_in        = src_q[0].be;
      tx_data_in_last = src_q[0].last;
      tx_data_in_rdy  = !src_q[0].hold;
    end else begin
      tx_data_in      = 32'h0;
      tx_be_in        = 4'h0;
      tx_data_in_last = 1'b0;
      tx_data_in_rdy  = 1'b0;
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_busy) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 4000) begin
      failures++;
      $display("FAIL %s_timeout actual=%0d cycles required=<4000", name, n);
    end
  endtask

  // FWFT source: a word is popped after the edge that ends its rd cycle.
  initial begin : src_proc
    drive_src();
    forever begin
      @(negedge clk);
      rd_prev = tx_data_in_rd;
      @(posedge clk);
      #1;
      if (rd_prev && src_q.size() > 0) void'(src_q.pop_front());
      drive_src();
    end
  end

  // Per-cycle compare against the expected stream, plus run/gap measurement.
  initial begin : cmp_proc
    item_t it;
    logic prev_en;
    active = 1'b0; prev_en = 1'b0;
    en_run = 0; gap = 0; last_run = 0; last_gap = 0; und_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0; prev_en = 1'b0; en_run = 0; gap = 0;
      end else begin
        if (gmii_tx_en) active = 1'b1;
        if (active) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL stream_extra actual=en%0b/txd%0h required=no activity", gmii_tx_en, gmii_txd);
            active = 1'b0;
          end else begin
            it = exp_q.pop_front();
            check("gmii_tx_en", {31'd0, gmii_tx_en}, {31'd0, it.en});
            check("gmii_tx_er", {31'd0, gmii_tx_er}, {31'd0, it.er});
            check("tx_underrun", {31'd0, tx_underrun}, {31'd0, it.und});
            if (!it.er) check("gmii_txd", {24'd0, gmii_txd}, {24'd0, it.d});
            check("tx_busy_frame", {31'd0, tx_busy}, 32'd1);
            if (exp_q.size() == 0) active = 1'b0;
          end
        end else begin
          check("idle_lines", {29'd0, gmii_tx_en, gmii_tx_er, tx_underrun}, 32'd0);
        end
        if (tx_underrun) und_cnt++;
        if (gmii_tx_en) begin
          if (!prev_en) last_gap = gap;
          en_run++;
        end else begin
          if (prev_en) begin
            last_run = en_run;
            en_run = 0;
            gap = 0;
          end
          gap++;
        end
        prev_en = gmii_tx_en;
      end
    end
  end

  initial begin : main_proc
    logic [31:0] c;
    string s;
    int u0;
    int n;
    rst_n = 1'b0;

    s = "123456789";
    c = 32'hFFFFFFFF;
    for (int i = 0; i < s.len(); i++) c = crc_byte(c, s[i]);
    check("model_crc_check_value", ~c, 32'hCBF43926);

    repeat (4) @(negedge clk);
    check("rst_tx_en", {31'd0, gmii_tx_en}, 32'd0);
    check("rst_tx_er", {31'd0, gmii_tx_er}, 32'd0);
    check("rst_txd", {24'd0, gmii_txd}, 32'd0);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_underrun", {31'd0, tx_underrun}, 32'd0);
    check("rst_rd", {31'd0, tx_data_in_rd}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    send_frame(64, -1, 4'hF, -1);
    wait_done("f64");
    check("f64_tx_en_len", last_run, 32'd76);

    send_frame(14, -1, 4'hF, -1);
    wait_done("f14");
    check("f14_tx_en_len", last_run, 32'd72);

    send_frame(20, -1, 4'hF, -1);
    send_frame(64, -1, 4'hF, -1);
    wait_done("b2b");
    check("b2b_ifg_gap", last_gap, 32'd12);

    u0 = und_cnt;
    send_frame(64, 4, 4'hF, -1);
    wait_done("underrun");
    check("underrun_tx_en_len", last_run, 32'd25);
    check("underrun_pulses", und_cnt - u0, 32'd1);
    src_q.delete();
    repeat (3) @(negedge clk);
    check("underrun_idle_busy", {31'd0, tx_busy}, 32'd0);

    // be=0000 on a non-last word counts as four bytes; be=1010 on the last as one.
    send_frame(8, -1, 4'h0, 4'b1010);
    wait_done("illegal_be_a");
    // be=0000 on the last word still carries one byte.
    send_frame(12, -1, 4'hF, 0);
    wait_done("illegal_be_b");

    send_frame(64, -1, 4'hF, -1);
    n = 0;
    while (!gmii_tx_en && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    src_q.delete();
    #1;
    check("async_rst_tx_en", {31'd0, gmii_tx_en}, 32'd0);
    check("async_rst_txd", {24'd0, gmii_txd}, 32'd0);
    check("async_rst_busy", {31'd0, tx_busy}, 32'd0);
    check("async_rst_tx_er", {31'd0, gmii_tx_er}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    send_frame(30, -1, 4'hF, -1);
    wait_done("post_reset");
    check("post_reset_tx_en_len", last_run, 32'd72);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
